r_type_control_fsm: RTL and testbench



---
 rtl/r_cpu_pkg.sv | 39 +++
 rtl/r_funct_decode.sv | 26 ++
 rtl/r_type_control_fsm.sv | 118 +++++++++++
 tb/tb_r_type_control_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/r_cpu_pkg.sv
// Shared encodings for the R-type multicycle controller: ALU operation codes,
// R-format funct codes and the controller state encoding.
package r_cpu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLLV = 3'b111;

  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Only add/sub produce a meaningful overflow flag from the ALU.
  function automatic logic op_has_overflow(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/r_funct_decode.sv
// Combinational funct -> ALU_OP decoder; valid is low for unsupported functs.
module r_funct_decode
  import r_cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = OP_AND;
    valid  = 1'b1;
    case (funct)
      FUNCT_AND:  alu_op = OP_AND;
      FUNCT_OR:   alu_op = OP_OR;
      FUNCT_XOR:  alu_op = OP_XOR;
      FUNCT_NOR:  alu_op = OP_NOR;
      FUNCT_ADD:  alu_op = OP_ADD;
      FUNCT_SUB:  alu_op = OP_SUB;
      FUNCT_SLTU: alu_op = OP_SLTU;
      FUNCT_SLLV: alu_op = OP_SLLV;
      default:    valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/r_type_control_fsm.sv
// Multicycle IF/ID/EX/WB controller for R-format instructions; one instruction
// per 4 cycles while run is high, every output registered or state-decoded.
module r_type_control_fsm
  import r_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        ZF,
  input  logic        OF,
  output logic        PC_Write,
  output logic        IR_Write,
  output logic        Reg_Write,
  output logic [2:0]  ALU_OP,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic        flag_z,
  output logic        flag_o,
  output logic        ovf_trap,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic [2:0]  dec_op;
  logic        dec_valid;
  logic        id_legal;
  logic        unused_shamt;

  r_funct_decode u_funct_decode (
    .funct  (ir[5:0]),
    .alu_op (dec_op),
    .valid  (dec_valid)
  );

  assign id_legal     = dec_valid && (ir[31:26] == OPCODE_RTYPE);
  assign unused_shamt = ^ir[10:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = run ? ST_IF : ST_IDLE;
      ST_IF:   state_nxt = ST_ID;
      ST_ID:   state_nxt = id_legal ? ST_EX : ST_HALT;
      ST_EX:   state_nxt = ST_WB;
      ST_WB:   state_nxt = run ? ST_IF : ST_IDLE;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    ovf_trap  = 1'b0;
    case (state)
      ST_IF: begin
        PC_Write = 1'b1;
        IR_Write = 1'b1;
      end
      ST_WB: begin
        Reg_Write = !flag_o;
        ovf_trap  = flag_o;
      end
      default: ;
    endcase
  end

  // Datapath registers: instruction latch, decoded fields, flags, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir      <= '0;
      ALU_OP  <= OP_AND;
      rs_addr <= '0;
      rt_addr <= '0;
      rd_addr <= '0;
      flag_z  <= 1'b0;
      flag_o  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_IF: ir <= inst;
        ST_ID: begin
          rs_addr <= ir[25:21];
          rt_addr <= ir[20:16];
          rd_addr <= ir[15:11];
          if (id_legal) begin
            ALU_OP <= dec_op;
          end else begin
            illegal <= 1'b1;
          end
        end
        ST_EX: begin
          flag_z <= ZF;
          // Mask OF for logic/shift ops so an undriven flag cannot leak in.
          flag_o <= op_has_overflow(ALU_OP) ? OF : 1'b0;
        end
        ST_WB: retired <= retired + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r_type_control_fsm.sv
// Scoreboarded bench for r_type_control_fsm: expected write-back entries are
// queued at issue and checked whenever the DUT pulses Reg_Write or ovf_trap.
`timescale 1ns/1ps
module tb_r_type_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] inst;
  logic        ZF;
  logic        OF;
  logic        PC_Write;
  logic        IR_Write;
  logic        Reg_Write;
  logic [2:0]  ALU_OP;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        flag_z;
  logic        flag_o;
  logic        ovf_trap;
  logic        illegal;
  logic [31:0] retired;

  r_type_control_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .inst      (inst),
    .ZF        (ZF),
    .OF        (OF),
    .PC_Write  (PC_Write),
    .IR_Write  (IR_Write),
    .Reg_Write (Reg_Write),
    .ALU_OP    (ALU_OP),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .flag_z    (flag_z),
    .flag_o    (flag_o),
    .ovf_trap  (ovf_trap),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        wr;
    logic        trap;
    logic        fz;
    logic        fo;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_retired = 32'd0;

  logic [5:0] sweep_funct [8];
  initial begin
    sweep_funct[0] = 6'b100100;
    sweep_funct[1] = 6'b100101;
    sweep_funct[2] = 6'b100110;
    sweep_funct[3] = 6'b100111;
    sweep_funct[4] = 6'b100000;
    sweep_funct[5] = 6'b100010;
    sweep_funct[6] = 6'b101011;
    sweep_funct[7] = 6'b000100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-back monitor: every WB pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst && (Reg_Write || ovf_trap)) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {30'd0, Reg_Write, ovf_trap}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_alu_op",    ALU_OP,    mon_e.op);
        check("wb_rd",        rd_addr,   mon_e.rd);
        check("wb_reg_write", Reg_Write, mon_e.wr);
        check("wb_ovf_trap",  ovf_trap,  mon_e.trap);
        check("wb_flag_z",    flag_z,    mon_e.fz);
        check("wb_flag_o",    flag_o,    mon_e.fo);
        check("wb_retired",   retired,   mon_e.ret);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_alu_op"},    ALU_OP,    32'd0);
    check({tag, "_rs"},        rs_addr,   32'd0);
    check({tag, "_rt"},        rt_addr,   32'd0);
    check({tag, "_rd"},        rd_addr,   32'd0);
    check({tag, "_flag_z"},    flag_z,    32'd0);
    check({tag, "_flag_o"},    flag_o,    32'd0);
    check({tag, "_illegal"},   illegal,   32'd0);
    check({tag, "_retired"},   retired,   32'd0);
    check({tag, "_pulses"},    {PC_Write, IR_Write, Reg_Write, ovf_trap}, 32'd0);
  endtask

  // Hold reset for one edge and check the reset state while it is asserted.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check_reset_values(tag);
    rst = 1'b0;
    sb.delete();
    exp_retired = 32'd0;
  endtask

  // Called at a negedge where the next rising edge moves the DUT into IF.
  // Legal instructions return at the WB negedge; illegal ones at the ID negedge.
  task automatic issue(input logic [31:0] iw, input logic zf, input logic of_in,
                       input logic legal, input logic [2:0] op, input logic drop_run);
    exp_t e;
    logic fo;
    fo = (op == 3'b100 || op == 3'b101) ? of_in : 1'b0;
    inst = iw;
    if (legal) begin
      e.op = op; e.rd = iw[15:11]; e.wr = !fo; e.trap = fo;
      e.fz = zf; e.fo = fo; e.ret = exp_retired;
      sb.push_back(e);
      exp_retired = exp_retired + 32'd1;
    end
    @(negedge clk);
    check("if_ir_write", IR_Write, 32'd1);
    check("if_pc_write", PC_Write, 32'd1);
    @(negedge clk);
    if (legal) begin
      @(negedge clk);
      check("ex_alu_op", ALU_OP,  op);
      check("ex_rd",     rd_addr, iw[15:11]);
      check("ex_rs",     rs_addr, iw[25:21]);
      check("ex_rt",     rt_addr, iw[20:16]);
      ZF = zf;
      OF = of_in;
      if (drop_run) run = 1'b0;
      @(negedge clk);
      ZF = 1'b0;
      OF = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; inst = 32'd0; ZF = 1'b0; OF = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // add $3,$1,$2 / sub with overflow / and with OF driven high (must be masked)
    run = 1'b1;
    issue(32'h00221820, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
    issue(32'h00221822, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0);
    issue(32'h00221824, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
    run = 1'b0;
    @(negedge clk);
    check("retired_after3", retired, exp_retired);
    @(negedge clk);
    check("idle_no_if", IR_Write, 32'd0);

    // non-R opcode halts; run stays high and nothing else may happen
    run = 1'b1;
    issue(32'h8C220000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_ir_write", IR_Write, 32'd0);
      check("halt_illegal",  illegal,  32'd1);
    end
    check("halt_retired", retired, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    do_reset("rst_halt");

    // sweep every supported funct back to back
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = {6'b000000, 5'd1, 5'd2, 5'(i + 3), 5'd0, sweep_funct[i]};
      issue(w, i[0], 1'b0, 1'b1, 3'(i), 1'b0);
    end
    issue(32'h00221800, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    check("funct0_illegal", illegal, 32'd1);
    check("sweep_retired",  retired, 32'd8);
    do_reset("rst_sweep");

    // drop run in EX: WB still happens, then IDLE with no further fetch
    run = 1'b1;
    issue(32'h00A63820, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_no_if", IR_Write, 32'd0);
    end
    check("drop_retired", retired, 32'd1);
    do_reset("rst_drop");

    // reset during ID abandons the instruction
    run = 1'b1;
    inst = 32'h00221820;
    @(negedge clk);
    check("id_rst_if", IR_Write, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("id_rst_retired", retired, 32'd0);
    check("id_rst_reg_write", Reg_Write, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("id_rst_idle", {PC_Write, IR_Write, Reg_Write, ovf_trap}, 32'd0);
    end
    check("id_rst_retired_end", retired, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
